// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared types and constants for the LUT configuration loaders.
package cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } cfg_state_e;

    // 16 data bits per LUT; the 4 select words reuse the same loader.
    localparam int LUT_CONFIG_WIDTH = 16;

endpackage

// File: rtl/lut_config_loader.sv
// rtl/lut_config_loader.sv - serial-to-parallel LUT config loader with atomic commit and bit forwarding.
module lut_config_loader
    import cfg_pkg::*;
#(
    parameter int CONFIG_WIDTH = LUT_CONFIG_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    config_enable,
    input  logic                    config_in,
    input  logic                    config_valid,
    output logic                    config_ready,
    output logic                    config_chain_out,
    output logic                    config_chain_valid,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_loaded,
    output logic                    config_done
);

    localparam int COUNT_WIDTH = $clog2(CONFIG_WIDTH + 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(CONFIG_WIDTH - 1);

    cfg_state_e              state_q, state_d;
    logic [CONFIG_WIDTH-1:0] shadow_q, shadow_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic                    chain_out_q, chain_out_d;
    logic                    chain_valid_q, chain_valid_d;
    logic [CONFIG_WIDTH-1:0] out_q, out_d;
    logic                    loaded_q, loaded_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shadow_q      <= '0;
            count_q       <= '0;
            chain_out_q   <= 1'b0;
            chain_valid_q <= 1'b0;
            out_q         <= '0;
            loaded_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            count_q       <= count_d;
            chain_out_q   <= chain_out_d;
            chain_valid_q <= chain_valid_d;
            out_q         <= out_d;
            loaded_q      <= loaded_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        count_d       = count_q;
        chain_out_d   = chain_out_q;
        chain_valid_d = 1'b0;
        out_d         = out_q;
        loaded_d      = loaded_q;
        config_ready  = 1'b0;
        config_done   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (config_enable) begin
                    state_d  = ST_SHIFT;
                    count_d  = '0;
                    shadow_d = '0;
                end
            end
            ST_SHIFT: begin
                config_ready = 1'b1;
                // Dropping enable aborts the session; the bit offered alongside is dropped too.
                if (!config_enable) begin
                    state_d  = ST_IDLE;
                    shadow_d = '0;
                    count_d  = '0;
                end else if (config_valid) begin
                    shadow_d      = {config_in, shadow_q[CONFIG_WIDTH-1:1]};
                    count_d       = count_q + COUNT_WIDTH'(1);
                    chain_out_d   = config_in;
                    chain_valid_d = 1'b1;
                    if (count_q == LAST_COUNT) begin
                        // Word is registered on the final accept so it is visible during COMMIT with done.
                        state_d  = ST_COMMIT;
                        out_d    = shadow_d;
                        loaded_d = 1'b1;
                        count_d  = '0;
                    end
                end
            end
            ST_COMMIT: begin
                config_done = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (!config_enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign config_chain_out   = chain_out_q;
    assign config_chain_valid = chain_valid_q;
    assign config_out         = out_q;
    assign config_loaded      = loaded_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// tb/tb_lut_config_loader.sv - scoreboard bench for lut_config_loader.
module tb_lut_config_loader;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         config_enable = 1'b0;
    logic         config_in = 1'b0;
    logic         config_valid = 1'b0;
    logic         config_ready;
    logic         config_chain_out;
    logic         config_chain_valid;
    logic [W-1:0] config_out;
    logic         config_loaded;
    logic         config_done;

    int checks = 0;
    int errors = 0;
    int chain_pulses = 0;
    int done_pulses = 0;

    logic         chain_q[$];
    logic [W-1:0] commit_q[$];

    lut_config_loader #(.CONFIG_WIDTH(W)) dut (
        .clock              (clock),
        .reset              (reset),
        .config_enable      (config_enable),
        .config_in          (config_in),
        .config_valid       (config_valid),
        .config_ready       (config_ready),
        .config_chain_out   (config_chain_out),
        .config_chain_valid (config_chain_valid),
        .config_out         (config_out),
        .config_loaded      (config_loaded),
        .config_done        (config_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (config_chain_valid) begin
                chain_pulses++;
                if (chain_q.size() == 0) chk("chain_valid_unexpected", 32'd1, 32'd0);
                else chk("chain_out_bit", {31'd0, config_chain_out}, {31'd0, chain_q.pop_front()});
            end
            if (config_done) begin
                done_pulses++;
                if (commit_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                else begin
                    chk("commit_word", {16'd0, config_out}, {16'd0, commit_q.pop_front()});
                    chk("commit_loaded", {31'd0, config_loaded}, 32'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Opens a session, streams nbits LSB-first, then closes the session.
    task automatic load(input logic [31:0] data, input int nbits, input bit gaps);
        config_enable = 1'b1;
        tick();
        for (int i = 0; i < nbits; i++) begin
            config_in    = data[i];
            config_valid = 1'b1;
            if (i < W) chain_q.push_back(data[i]);
            if (i == W - 1) commit_q.push_back(data[W-1:0]);
            if (i >= W) begin
                #3;
                chk("overrun_ready", {31'd0, config_ready}, 32'd0);
            end
            tick();
            if (i == W - 1) begin
                #3;
                chk("commit_latency_done", {31'd0, config_done}, 32'd1);
                chk("commit_latency_out", {16'd0, config_out}, {16'd0, data[W-1:0]});
                @(posedge clock);
                #1;
                if (i + 1 < nbits) begin
                    config_in = data[i+1];
                end
            end
            if (gaps) begin
                config_valid = 1'b0;
                tick();
            end
        end
        config_valid = 1'b0;
        repeat (3) tick();
        config_enable = 1'b0;
        tick();
    endtask

    initial begin
        int base_chain;
        int base_done;

        // Async reset asserted before any clock edge.
        #1 reset = 1'b1;
        #2;
        chk("rst_out", {16'd0, config_out}, 32'd0);
        chk("rst_loaded", {31'd0, config_loaded}, 32'd0);
        chk("rst_ready", {31'd0, config_ready}, 32'd0);
        chk("rst_chain_valid", {31'd0, config_chain_valid}, 32'd0);
        chk("rst_done", {31'd0, config_done}, 32'd0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        tick();
        chk("idle_ready", {31'd0, config_ready}, 32'd0);

        load(32'h8001, W, 1'b0);
        chk("full_out", {16'd0, config_out}, 32'h8001);
        chk("full_loaded", {31'd0, config_loaded}, 32'd1);

        base_chain = chain_pulses;
        load(32'hA5C3, W, 1'b1);
        chk("gap_out", {16'd0, config_out}, 32'hA5C3);
        chk("gap_chain_count", chain_pulses - base_chain, 32'd16);

        load(32'hFFFF, W, 1'b0);
        base_done = done_pulses;
        config_enable = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            config_in = 1'b0;
            config_valid = 1'b1;
            chain_q.push_back(1'b0);
            tick();
        end
        config_valid = 1'b0;
        config_enable = 1'b0;
        repeat (3) tick();
        chk("abort_out_kept", {16'd0, config_out}, 32'hFFFF);
        chk("abort_no_done", done_pulses - base_done, 32'd0);
        load(32'h1234, W, 1'b0);
        chk("after_abort_out", {16'd0, config_out}, 32'h1234);

        base_chain = chain_pulses;
        load(32'hF_5A0F, 20, 1'b0);
        chk("overrun_out", {16'd0, config_out}, 32'h5A0F);
        chk("overrun_chain_count", chain_pulses - base_chain, 32'd16);

        base_chain = chain_pulses;
        config_enable = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            config_in = 1'b1;
            config_valid = 1'b1;
            chain_q.push_back(1'b1);
            tick();
        end
        config_enable = 1'b0;
        config_in = 1'b1;
        config_valid = 1'b1;
        tick();
        config_valid = 1'b0;
        #3;
        chk("abortv_ready", {31'd0, config_ready}, 32'd0);
        chk("abortv_chain_count", chain_pulses - base_chain, 32'd3);
        tick();
        chk("abortv_out_kept", {16'd0, config_out}, 32'h5A0F);
        load(32'h0F0F, W, 1'b0);
        chk("after_abortv_out", {16'd0, config_out}, 32'h0F0F);

        // Reset in the middle of a session, away from any clock edge.
        config_enable = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            config_in = 1'b1;
            config_valid = 1'b1;
            chain_q.push_back(1'b1);
            tick();
        end
        config_valid = 1'b0;
        #6 reset = 1'b1;
        #1;
        chk("midrst_out", {16'd0, config_out}, 32'd0);
        chk("midrst_loaded", {31'd0, config_loaded}, 32'd0);
        chk("midrst_ready", {31'd0, config_ready}, 32'd0);
        chk("midrst_chain_out", {31'd0, config_chain_out}, 32'd0);
        chain_q.delete();
        config_enable = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        tick();
        load(32'hC3A5, W, 1'b0);
        chk("post_rst_out", {16'd0, config_out}, 32'hC3A5);

        repeat (2) tick();
        chk("chain_q_drained", chain_q.size(), 32'd0);
        chk("commit_q_drained", commit_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
